// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - four-digit BCD event counter with multiplexed digit scanner
//
// Counts prescaled enable ticks in BCD (0000..9999, wrapping) and scans the
// four digits onto a single decoder input with matching active-low anode select.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-high reset, highest priority
//   en         count enable; gates the prescaler only
//   clear      synchronous clear of count and prescaler (scanner unaffected)
//   count_bcd  registered count, [3:0]=units .. [15:12]=thousands
//   digit_out  BCD nibble of the currently scanned digit
//   digit_sel  registered active-low one-hot anode select
//   rollover   registered one-cycle pulse on the 9999->0000 wrap

module bcd_scan_counter #(
    parameter int PRESCALE = 4,
    parameter int SCAN_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clear,
    output logic [15:0] count_bcd,
    output logic [3:0]  digit_out,
    output logic [3:0]  digit_sel,
    output logic        rollover
);

    // A width of at least one bit keeps the divide-by-1 cases well formed.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [15:0]   count_q, count_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          roll_q, roll_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    sel_q, sel_d;
    logic          tick;

    // Ripple-carry BCD increment: a 9 becomes 0 and passes the carry upward.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick = en && (pre_q == PRE_LAST);

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        roll_d  = 1'b0;
        if (clear) begin
            // Clear outranks a coincident tick, so no rollover pulse either.
            count_d = 16'h0000;
            pre_d   = '0;
        end else if (tick) begin
            count_d = bcd_inc(count_q);
            pre_d   = '0;
            roll_d  = (count_q == 16'h9999);
        end else if (en) begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Scanner is free-running; only reset touches it.
    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end
        case (idx_d)
            2'd0:    sel_d = 4'b1110;
            2'd1:    sel_d = 4'b1101;
            2'd2:    sel_d = 4'b1011;
            default: sel_d = 4'b0111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'h0000;
            pre_q   <= '0;
            roll_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= 2'd0;
            sel_q   <= 4'b1110;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            roll_q  <= roll_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
        end
    end

    // Selected from registered index and count so it always matches digit_sel.
    always_comb begin
        case (idx_q)
            2'd0:    digit_out = count_q[3:0];
            2'd1:    digit_out = count_q[7:4];
            2'd2:    digit_out = count_q[11:8];
            default: digit_out = count_q[15:12];
        endcase
    end

    assign count_bcd = count_q;
    assign digit_sel = sel_q;
    assign rollover  = roll_q;

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Four-digit BCD event counter with a time-multiplexed digit scanner.
- Sits directly upstream of the seven-segment decoder.
- digit_out drives the decoder's 4-bit digit input; digit_sel drives the display anodes for the digit currently presented.
- Counts prescaled enable ticks (0000..9999, wrapping) and cycles the four digits continuously so a single decoder serves the whole display.

Parameters:
- PRESCALE, 4, clock cycles per count tick while en=1; legal range >=1.
- SCAN_DIV, 2, clock cycles each digit is held before the scanner advances; legal range >=1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; gates the prescaler only, not the scanner.
- clear  input  1  synchronous clear of count and prescaler.
- count_bcd  output  16  current count, 4 BCD digits, [3:0]=units … [15:12]=thousands; registered.
- digit_out  output  4  BCD nibble of the digit selected by the scan index; feeds the decoder input.
- digit_sel  output  4  active-low one-hot anode select; bit i low means digit i is shown.
- rollover  output  1  one-cycle pulse on the 9999->0000 wrap; registered.

Behaviour:
- Reset is synchronous, active-high, and has highest priority. On reset:
  - count_bcd=16'h0000, prescaler=0, rollover=0.
  - Scan counter=0, scan index=0, digit_sel=4'b1110, digit_out=4'h0.
- Prescaler counts 0..PRESCALE-1 while en=1 and holds its value while en=0.
  - A tick occurs in the cycle where prescaler==PRESCALE-1 and en=1; the prescaler then returns to 0.
  - PRESCALE=1 means a tick on every en cycle.
- On a tick, count_bcd increments in BCD with ripple carry.
  - Any digit at 9 goes to 0 and carries into the next digit.
  - count_bcd is never non-BCD (no digit above 9).
- 9999 + tick gives 0000, and rollover=1 on the following cycle only.
  - rollover is 0 in every other cycle, including after a clear.
- clear (sync, below reset, above tick): count_bcd=0, prescaler=0, rollover=0 next cycle. The scanner is unaffected.
- When clear and a tick coincide, clear wins; no rollover pulse is issued.
- Scanner runs free whenever reset=0, regardless of en or clear.
  - Scan counter counts 0..SCAN_DIV-1.
  - On wrap, the scan index advances 0->1->2->3->0.
- digit_sel is registered and decoded from the scan index: index 0:1110, 1:1101, 2:1011, 3:0111.
  - Exactly one bit is low at all times after reset.
- digit_out = count_bcd nibble[index], combinational from registered state.
  - It is always consistent with digit_sel in the same cycle.
  - It reflects a count change in the same cycle count_bcd updates; there is no extra latency.
- Latency:
  - A tick edge is visible on count_bcd one cycle later.
  - rollover asserts in the same cycle that count_bcd shows 0000 after the wrap.
- Toggling en mid-prescale: the prescaler holds its value and resumes without a reset, so partial periods accumulate.
- Reset mid-operation returns all state to the reset values in the next cycle, irrespective of en or clear.

Test Plan:
- Reset release, PRESCALE=4, en=1 for 40 cycles:
  - count_bcd increments every 4 cycles.
  - After 40 cycles count_bcd=16'h0010 (ten ticks, units 9->0 with carry to tens).
- Scanner, SCAN_DIV=2, count forced to 16'h1234 by ticking:
  - digit_sel sequence 1110,1101,1011,0111, each held 2 cycles.
  - digit_out sequence 4,3,2,1 in lockstep.
  - The scanner keeps running with en=0.
- Wrap: tick from 16'h9999:
  - count_bcd=16'h0000.
  - rollover high exactly one cycle, then low.
- en gating: en=1 for 2 cycles, en=0 for 5, en=1 for 2 -> exactly one tick, count_bcd=16'h0001.
- clear coincident with a tick at 16'h9999 -> count_bcd=0000, rollover stays 0, digit_sel sequence uninterrupted.
- Reset asserted mid-count at 16'h0457 with digit index 2:
  - Next cycle count_bcd=0, digit_sel=1110, digit_out=0, rollover=0.
